// File: rtl/mem_arbiter_seq.sv
// Byte-serial memory arbiter: fetch/load/store channels onto one byte-wide synchronous port.
// Define RR_ARB_EN for round-robin arbitration; the default is fixed priority ld > st > if.
module mem_arbiter_seq #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned IF_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ld_req,
    input  logic [2:0]        ld_size,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_done,
    output logic [31:0]       ld_data,
    input  logic              st_req,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_done
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_DRAIN, S_WR, S_DONE} state_t;

    localparam logic [1:0]  CH_IF   = 2'd0;
    localparam logic [1:0]  CH_LD   = 2'd1;
    localparam logic [1:0]  CH_ST   = 2'd2;
    localparam logic [1:0]  IF_NBM1 = 2'(IF_BYTES - 1);
    localparam logic [31:0] IF_MASK = (IF_BYTES == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    state_t             state_q, state_n;
    logic [1:0]         ch_q, ch_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [2:0]         size_q, size_n;
    logic [31:0]        sdata_q, sdata_n;
    logic [1:0]         nbm1_q, nbm1_n;
    logic [1:0]         beat_q, beat_n, beat_inc;
    logic [1:0]         cap_q, cap_n;
    logic [31:0]        rbuf_q, rbuf_n, merged_c;
    logic               masked_q;
    logic [RD_LAT-1:0]  vld_q;
    logic [RD_LAT:0]    vld_all_c;
    logic               cap_c;

    logic [ADDR_W-1:0]  mem_a_n;
    logic [7:0]         mem_dout_n;
    logic               mem_wr_n;

    logic [2:0]         req_c;
    logic               gnt_c;
    logic [1:0]         gch_c;
    logic [ADDR_W-1:0]  g_addr;
    logic [2:0]         g_size;
    logic [1:0]         g_nbm1;
    logic               g_ok;

    function automatic logic [31:0] ld_ext(input logic [31:0] b, input logic [2:0] sz);
        case (sz)
            3'b000:  ld_ext = {{24{b[7]}}, b[7:0]};
            3'b001:  ld_ext = {{16{b[15]}}, b[15:0]};
            3'b010:  ld_ext = b;
            3'b100:  ld_ext = {24'h0, b[7:0]};
            3'b101:  ld_ext = {16'h0, b[15:0]};
            default: ld_ext = 32'h0;
        endcase
    endfunction

    // The channel that just completed is hidden for one IDLE cycle.
    always_comb begin
        req_c        = 3'b000;
        req_c[CH_IF] = if_req && !(masked_q && ch_q == CH_IF);
        req_c[CH_LD] = ld_req && !(masked_q && ch_q == CH_LD);
        req_c[CH_ST] = st_req && !(masked_q && ch_q == CH_ST);
    end

`ifdef RR_ARB_EN
    logic [1:0] ptr_q, ptr_n;
    logic [2:0] rr_idx;

    always_comb begin
        gnt_c  = 1'b0;
        gch_c  = CH_LD;
        ptr_n  = ptr_q;
        rr_idx = 3'd0;
        for (int i = 0; i < 3; i++) begin
            rr_idx = 3'(ptr_q) + 3'(i);
            if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
            if (!gnt_c && req_c[rr_idx[1:0]]) begin
                gnt_c = 1'b1;
                gch_c = rr_idx[1:0];
            end
        end
        if (gnt_c) ptr_n = (gch_c == CH_ST) ? CH_IF : gch_c + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ptr_q <= CH_LD;
        else if (state_q == S_IDLE && gnt_c) ptr_q <= ptr_n;
    end
`else
    always_comb begin
        gnt_c = |req_c;
        gch_c = CH_IF;
        if (req_c[CH_LD])      gch_c = CH_LD;
        else if (req_c[CH_ST]) gch_c = CH_ST;
    end
`endif

    // Decode the granted channel's address, size and beat count.
    always_comb begin
        g_addr = if_addr;
        g_size = 3'b010;
        g_nbm1 = IF_NBM1;
        g_ok   = 1'b1;
        case (gch_c)
            CH_LD: begin
                g_addr = ld_addr;
                g_size = ld_size;
                case (ld_size)
                    3'b000, 3'b100: g_nbm1 = 2'd0;
                    3'b001, 3'b101: g_nbm1 = 2'd1;
                    3'b010:         g_nbm1 = 2'd3;
                    default: begin
                        g_nbm1 = 2'd0;
                        g_ok   = 1'b0;
                    end
                endcase
            end
            CH_ST: begin
                g_addr = st_addr;
                g_size = {1'b0, st_size};
                case (st_size)
                    2'b01:   g_nbm1 = 2'd0;
                    2'b10:   g_nbm1 = 2'd1;
                    2'b11:   g_nbm1 = 2'd3;
                    default: begin
                        g_nbm1 = 2'd0;
                        g_ok   = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Read-valid pipeline: bit k set means an address was issued k cycles ago.
    assign vld_all_c = {vld_q, state_q == S_RD};
    assign cap_c     = vld_all_c[RD_LAT];
    assign beat_inc  = beat_q + 2'd1;

    always_comb begin
        merged_c = rbuf_q;
        if (cap_c) merged_c[{cap_q, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n    = state_q;
        ch_n       = ch_q;
        addr_n     = addr_q;
        size_n     = size_q;
        sdata_n    = sdata_q;
        nbm1_n     = nbm1_q;
        beat_n     = beat_q;
        cap_n      = cap_c ? cap_q + 2'd1 : cap_q;
        rbuf_n     = merged_c;
        mem_a_n    = '0;
        mem_dout_n = 8'h00;
        mem_wr_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_c) begin
                    ch_n    = gch_c;
                    addr_n  = g_addr;
                    size_n  = g_size;
                    sdata_n = st_data;
                    nbm1_n  = g_nbm1;
                    beat_n  = 2'd0;
                    cap_n   = 2'd0;
                    rbuf_n  = 32'h0;
                    if (!g_ok) begin
                        state_n = S_DONE;
                    end else if (gch_c == CH_ST) begin
                        state_n    = S_WR;
                        mem_wr_n   = 1'b1;
                        mem_a_n    = g_addr;
                        mem_dout_n = st_data[7:0];
                    end else begin
                        state_n = S_RD;
                        mem_a_n = g_addr;
                    end
                end
            end
            S_RD: begin
                if (beat_q == nbm1_q) begin
                    state_n = S_RD_DRAIN;
                end else begin
                    beat_n  = beat_inc;
                    mem_a_n = addr_q + ADDR_W'(beat_inc);
                end
            end
            S_RD_DRAIN: begin
                if (cap_c && cap_q == nbm1_q) state_n = S_DONE;
            end
            S_WR: begin
                if (beat_q == nbm1_q) begin
                    state_n = S_DONE;
                end else begin
                    beat_n     = beat_inc;
                    mem_wr_n   = 1'b1;
                    mem_a_n    = addr_q + ADDR_W'(beat_inc);
                    mem_dout_n = sdata_q[{beat_inc, 3'b000} +: 8];
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Transaction context, memory-port outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q     <= CH_IF;
            addr_q   <= '0;
            size_q   <= 3'b000;
            sdata_q  <= 32'h0;
            nbm1_q   <= 2'd0;
            beat_q   <= 2'd0;
            cap_q    <= 2'd0;
            rbuf_q   <= 32'h0;
            masked_q <= 1'b0;
            vld_q    <= '0;
            mem_a    <= '0;
            mem_dout <= 8'h00;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            if_data  <= 32'h0;
            ld_data  <= 32'h0;
        end else begin
            ch_q     <= ch_n;
            addr_q   <= addr_n;
            size_q   <= size_n;
            sdata_q  <= sdata_n;
            nbm1_q   <= nbm1_n;
            beat_q   <= beat_n;
            cap_q    <= cap_n;
            rbuf_q   <= rbuf_n;
            masked_q <= (state_q == S_DONE);
            vld_q    <= vld_all_c[RD_LAT-1:0];
            mem_a    <= mem_a_n;
            mem_dout <= mem_dout_n;
            mem_wr   <= mem_wr_n;
            if_done  <= (state_n == S_DONE) && (ch_n == CH_IF);
            ld_done  <= (state_n == S_DONE) && (ch_n == CH_LD);
            st_done  <= (state_n == S_DONE) && (ch_n == CH_ST);
            if (state_n == S_DONE && ch_n == CH_IF) if_data <= rbuf_n & IF_MASK;
            if (state_n == S_DONE && ch_n == CH_LD) ld_data <= ld_ext(rbuf_n, size_n);
        end
    end

endmodule

// File: tb/tb_mem_arbiter_seq.sv
// Directed self-checking bench for mem_arbiter_seq (default build, RD_LAT=1, IF_BYTES=4).
module tb_mem_arbiter_seq;

    logic        clk;
    logic        rst_n;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ld_req;
    logic [2:0]  ld_size;
    logic [31:0] ld_addr;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_done;

    int checks = 0;
    int errors = 0;

    mem_arbiter_seq #(.ADDR_W(32), .RD_LAT(1), .IF_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_din(mem_din), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_size(ld_size), .ld_addr(ld_addr),
        .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_size(st_size), .st_addr(st_addr),
        .st_data(st_data), .st_done(st_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory, one-cycle read latency, low 12 address bits.
    logic [7:0] mem [0:4095];
    logic       mem_ready;
    always @(posedge clk) begin
        if (mem_ready !== 1'b1) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'h11; mem[12'h101] <= 8'h22;
            mem[12'h102] <= 8'h33; mem[12'h103] <= 8'h44;
            mem[12'h080] <= 8'h80;
            mem[12'h010] <= 8'h34; mem[12'h011] <= 8'h85;
            mem[12'h300] <= 8'h13; mem[12'h301] <= 8'h05;
            mem[12'h302] <= 8'h10; mem[12'h303] <= 8'h00;
            mem[12'hFFE] <= 8'hAA; mem[12'hFFF] <= 8'hBB;
            mem[12'h000] <= 8'hCC; mem[12'h001] <= 8'hDD;
            mem_ready    <= 1'b1;
            mem_din      <= 8'h00;
        end else begin
            if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
            mem_din <= mem[mem_a[11:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] exp, input string tag);
        int n;
        ld_size = sz;
        ld_addr = a;
        ld_req  = 1'b1;
        n = 0;
        while (!ld_done && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(ld_done), 32'd1);
        chk(tag, ld_data, exp);
        ld_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int order [0:2];
        int ndone;
        int n;
        logic seen;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ld_req = 1'b0; ld_size = 3'b000; ld_addr = 32'h0;
        st_req = 1'b0; st_size = 2'b00; st_addr = 32'h0; st_data = 32'h0;
        tick(); tick(); tick();

        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_dones", {29'h0, if_done, ld_done, st_done}, 32'h0);
        chk("rst_data", if_data | ld_data, 32'h0);

        rst_n = 1'b1;
        tick(); tick();

        // LW 0x100: addresses at G+1..G+4, done at G+6; address changed after grant.
        ld_req = 1'b1; ld_size = 3'b010; ld_addr = 32'h100;
        tick();
        ld_addr = 32'hABC;
        chk("lw_a0", mem_a, 32'h100);
        chk("lw_wr0", 32'(mem_wr), 32'd0);
        tick(); chk("lw_a1", mem_a, 32'h101);
        tick(); chk("lw_a2", mem_a, 32'h102);
        tick(); chk("lw_a3", mem_a, 32'h103);
        tick(); chk("lw_a_idle", mem_a, 32'h0);
        chk("lw_early_done", 32'(ld_done), 32'd0);
        tick();
        chk("lw_done", 32'(ld_done), 32'd1);
        chk("lw_data", ld_data, 32'h4433_2211);
        ld_req = 1'b0;
        tick();
        chk("lw_done_pulse", 32'(ld_done), 32'd0);
        chk("lw_data_hold", ld_data, 32'h4433_2211);
        tick();

        do_load(3'b000, 32'h80, 32'hFFFF_FF80, "lb");
        do_load(3'b100, 32'h80, 32'h0000_0080, "lbu");
        do_load(3'b001, 32'h10, 32'hFFFF_8534, "lh");
        do_load(3'b101, 32'h10, 32'h0000_8534, "lhu");

        // Invalid load size: done at G+1, no access, data cleared.
        ld_req = 1'b1; ld_size = 3'b011; ld_addr = 32'h100;
        tick();
        chk("inv_done", 32'(ld_done), 32'd1);
        chk("inv_data", ld_data, 32'h0);
        chk("inv_mem_a", mem_a, 32'h0);
        ld_req = 1'b0;
        tick(); tick();

        // SW 0xDEADBEEF to 0x200.
        st_req = 1'b1; st_size = 2'b11; st_addr = 32'h200; st_data = 32'hDEAD_BEEF;
        tick();
        st_data = 32'h0;
        chk("sw_b0", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0200, 8'h01, 8'hEF});
        tick(); chk("sw_b1", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0201, 8'h01, 8'hBE});
        tick(); chk("sw_b2", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0202, 8'h01, 8'hAD});
        tick(); chk("sw_b3", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0203, 8'h01, 8'hDE});
        tick();
        chk("sw_done", 32'(st_done), 32'd1);
        chk("sw_wr_off", 32'(mem_wr), 32'd0);
        st_req = 1'b0;
        tick(); tick();
        do_load(3'b010, 32'h200, 32'hDEAD_BEEF, "sw_readback");

        // All three channels request together: expect ld, st, if.
        ld_req = 1'b1; ld_size = 3'b010; ld_addr = 32'h100;
        st_req = 1'b1; st_size = 2'b01; st_addr = 32'h304; st_data = 32'h0000_0055;
        if_req = 1'b1; if_addr = 32'h300;
        ndone = 0; n = 0;
        for (int i = 0; i < 3; i++) order[i] = -1;
        while (ndone < 3 && n < 80) begin
            tick();
            n++;
            if (32'(if_done) + 32'(ld_done) + 32'(st_done) > 32'd1)
                chk("arb_one_done", 32'(if_done) + 32'(ld_done) + 32'(st_done), 32'd1);
            if (ld_done) begin order[ndone] = 1; ndone++; ld_req = 1'b0; end
            else if (st_done) begin order[ndone] = 2; ndone++; st_req = 1'b0; end
            else if (if_done) begin order[ndone] = 0; ndone++; if_req = 1'b0; end
        end
        chk("arb_count", 32'(ndone), 32'd3);
        chk("arb_first", 32'(order[0]), 32'd1);
        chk("arb_second", 32'(order[1]), 32'd2);
        chk("arb_third", 32'(order[2]), 32'd0);
        chk("arb_if_data", if_data, 32'h0010_0513);
        chk("arb_ld_data", ld_data, 32'h4433_2211);
        chk("arb_sb_mem", 32'(mem[12'h304]), 32'h55);
        tick(); tick();

        // Fetch wrapping past the top of the address space.
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
        tick(); chk("wrap_a0", mem_a, 32'hFFFF_FFFE);
        tick(); chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
        tick(); chk("wrap_a2", mem_a, 32'h0000_0000);
        tick(); chk("wrap_a3", mem_a, 32'h0000_0001);
        tick(); tick();
        chk("wrap_done", 32'(if_done), 32'd1);
        chk("wrap_data", if_data, 32'hDDCC_BBAA);
        if_req = 1'b0;
        tick(); tick();

        // Reset during write beat 2.
        st_req = 1'b1; st_size = 2'b11; st_addr = 32'h400; st_data = 32'h1122_3344;
        tick();
        chk("rstw_b0", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0400, 8'h01, 8'h44});
        tick();
        chk("rstw_b1", {mem_a[15:0], 7'h0, mem_wr, mem_dout}, {16'h0401, 8'h01, 8'h33});
        rst_n = 1'b0;
        #1;
        chk("rstw_wr_drop", 32'(mem_wr), 32'd0);
        chk("rstw_a_drop", mem_a, 32'h0);
        st_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (st_done) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (st_done) seen = 1'b1;
        end
        chk("rstw_no_done", 32'(seen), 32'd0);
        chk("rstw_outs", {mem_a[23:0], mem_dout}, 32'h0);
        chk("rstw_ctl", {28'h0, mem_wr, if_done, ld_done, st_done}, 32'h0);
        chk("rstw_data", if_data | ld_data, 32'h0);
        chk("rstw_mem0", 32'(mem[12'h400]), 32'h44);
        chk("rstw_mem1", 32'(mem[12'h401]), 32'h00);
        do_load(3'b010, 32'h100, 32'h4433_2211, "post_rst_lw");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
